// File: rtl/das_reset_sequencer.sv
// Power-up / restart sequencer for DAS front-end devices: global reset, staggered release,
// per-device holdoff, ready wait with timeout. Optional macro DAS_READY_SYNC_EN adds a 2-flop ready synchronizer.
`timescale 1ns/1ps
module das_reset_sequencer #(
  parameter int NDEV     = 4,
  parameter int RESETLEN = 65536,
  parameter int HOLDOFF  = 1024,
  parameter int TIMEOUT  = 1048576
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            en_i,
  input  logic            restart_i,
  input  logic [NDEV-1:0] dev_ready_i,
  output logic [NDEV-1:0] dev_reset_o,
  output logic            acq_en_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [NDEV-1:0] fault_mask_o
);

  localparam int MAX_RH = (RESETLEN > HOLDOFF) ? RESETLEN : HOLDOFF;
  localparam int CMAX   = (MAX_RH > TIMEOUT) ? MAX_RH : TIMEOUT;
  localparam int CNTW   = $clog2(CMAX) + 1;
  localparam int IDXW   = (NDEV > 1) ? $clog2(NDEV) : 1;

  localparam logic [CNTW-1:0] RESET_LAST = CNTW'(RESETLEN - 1);
  localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(HOLDOFF - 1);
  localparam logic [CNTW-1:0] TOUT_LAST  = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_SAT    = '1;
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NDEV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT, S_RELEASE, S_HOLDOFF, S_WAIT_RDY, S_RUN, S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NDEV-1:0] dev_reset_q, dev_reset_d;
  logic [NDEV-1:0] mask_q, mask_d;
  logic            acq_en_q, busy_q, done_q, fault_q;
  logic            enter, advance;
  logic [NDEV-1:0] rdy;

`ifdef DAS_READY_SYNC_EN
  logic [NDEV-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= dev_ready_i;
      sync_q2 <= sync_q1;
    end
  end

  assign rdy = sync_q2;
`else
  assign rdy = dev_ready_i;
`endif

  // Output registers are loaded with the values of the state being entered,
  // so every output changes on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dev_reset_d = dev_reset_q;
    mask_d      = mask_q;
    enter       = 1'b0;
    advance     = 1'b0;
    cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_ASSERT;
          enter   = 1'b1;
        end
      end
      S_ASSERT: begin
        if (cnt_q == RESET_LAST) begin
          state_d        = S_RELEASE;
          idx_d          = '0;
          dev_reset_d[0] = 1'b0;
          enter          = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_HOLDOFF;
        enter   = 1'b1;
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT_RDY;
          enter   = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (rdy[idx_q]) begin
          advance = 1'b1;
        end else if (cnt_q == TOUT_LAST) begin
          mask_d[idx_q]      = 1'b1;
          dev_reset_d[idx_q] = 1'b1;
          advance            = 1'b1;
        end
        if (advance) begin
          enter = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = (mask_d == '0) ? S_RUN : S_FAULT;
          end else begin
            state_d            = S_RELEASE;
            idx_d              = idx_q + 1'b1;
            dev_reset_d[idx_d] = 1'b0;
          end
        end
      end
      S_RUN, S_FAULT: ;
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase

    // Enable dominates restart, restart dominates the sequence.
    if (restart_i && state_q != S_IDLE) begin
      state_d = S_ASSERT;
      idx_d   = '0;
      enter   = 1'b1;
    end
    if (!en_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      enter   = 1'b1;
    end

    if (state_d == S_IDLE || (enter && state_d == S_ASSERT)) begin
      dev_reset_d = '1;
      mask_d      = '0;
    end
    if (enter) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      dev_reset_q <= '1;
      mask_q      <= '0;
      acq_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dev_reset_q <= dev_reset_d;
      mask_q      <= mask_d;
      acq_en_q    <= (state_d == S_RUN);
      busy_q      <= (state_d == S_ASSERT) || (state_d == S_RELEASE) ||
                     (state_d == S_HOLDOFF) || (state_d == S_WAIT_RDY);
      done_q      <= (state_d == S_RUN) || (state_d == S_FAULT);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign dev_reset_o  = dev_reset_q;
  assign acq_en_o     = acq_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;
  assign fault_mask_o = mask_q;

endmodule

// File: doc/das_reset_sequencer.md
Name: das_reset_sequencer

Overview:
Power-up and restart sequencer for the DAS front-end devices (ADCs/PGAs) on the 200 MHz acquisition clock.
- Holds all devices in reset for a fixed period, then releases them one at a time in staggered order.
- Waits a fixed holdoff after each release, then waits for that device's ready flag, with a timeout per device.
- Enables the acquisition datapath only when every device has come up; otherwise reports which devices failed.

Parameters:
NDEV, 4, number of sequenced devices (1..16)
RESETLEN, 65536, cycles all dev_reset_o are held high in ASSERT (>=1)
HOLDOFF, 1024, cycles waited after each release before ready is checked (>=1)
TIMEOUT, 1048576, max cycles spent in WAIT_RDY per device (>=1)

Ports:
clk_i  input  1  acquisition clock; all logic on its rising edge
resetn_i  input  1  synchronous, active-low reset
en_i  input  1  sequencer enable; low forces IDLE
restart_i  input  1  single-cycle pulse that restarts the sequence from ASSERT
dev_ready_i  input  NDEV  per-device ready/not-busy flag, active high
dev_reset_o  output  NDEV  per-device reset, active high, registered
acq_en_o  output  1  acquisition enable to the datapath, registered
busy_o  output  1  sequence in progress (ASSERT, RELEASE, HOLDOFF, WAIT_RDY)
done_o  output  1  sequence finished (RUN or FAULT)
fault_o  output  1  at least one device timed out (FAULT)
fault_mask_o  output  NDEV  bit i set = device i timed out during the last sequence

Behaviour:
- Single clock clk_i. Reset is synchronous and active-low on resetn_i. All outputs are registered.
- Reset values: state=IDLE, dev_reset_o=all 1s, acq_en_o=0, busy_o=0, done_o=0, fault_o=0, fault_mask_o=0, idx=0, cnt=0.
- Counter cnt is $clog2(max(RESETLEN,HOLDOFF,TIMEOUT))+1 bits wide, is cleared on every state entry, and saturates rather than wraps.
- Index idx is $clog2(NDEV) bits wide, minimum 1.
- IDLE:
  - dev_reset_o all 1s; all status outputs 0.
  - en_i=1 -> ASSERT.
- ASSERT:
  - dev_reset_o all 1s; busy_o=1; fault_mask_o cleared on entry.
  - Stays exactly RESETLEN cycles (cnt = RESETLEN-1 -> RELEASE, idx=0).
- RELEASE (1 cycle):
  - Clear dev_reset_o[idx]; already-released devices stay released.
  - -> HOLDOFF.
- HOLDOFF:
  - Stays exactly HOLDOFF cycles; ready is ignored.
  - -> WAIT_RDY.
- WAIT_RDY:
  - Ready path: if rdy[idx]=1, go to RELEASE with idx+1 when idx<NDEV-1. When idx=NDEV-1, go to RUN if fault_mask is 0, else FAULT.
  - Timeout path: if cnt reaches TIMEOUT-1 with rdy[idx]=0, set fault_mask_o[idx] and re-assert dev_reset_o[idx]. The next-state rule is the same as the ready path.
  - If ready is seen on the timeout cycle, ready wins.
- RUN:
  - acq_en_o=1, done_o=1, busy_o=0.
  - Any rdy bit of a released device falling does not change state; the datapath owns that condition.
- FAULT:
  - acq_en_o=0, done_o=1, fault_o=1.
  - Failed devices stay in reset; fault_mask_o is held.
- Priority, highest first: resetn_i, then en_i=0, then restart_i, then normal transitions.
- en_i=0 in any state -> IDLE on the next edge, with IDLE output values including fault_mask_o=0.
- restart_i=1 while en_i=1, in any state other than IDLE -> ASSERT next edge:
  - all dev_reset_o re-asserted and acq_en_o dropped on that same edge;
  - applies mid-sequence too;
  - restart_i in IDLE is ignored.
- rdy is defined in Optional Feature.
- Sequence length with all devices ready immediately, excluding sync latency: RESETLEN + NDEV*(1+HOLDOFF+1) cycles from ASSERT entry to RUN entry.

Optional Feature:
Macro DAS_READY_SYNC_EN.
- Defined: dev_ready_i passes through a 2-flop synchronizer per bit, reset to 0. rdy is the synchronized value, adding 2 cycles of ready latency. Use this for devices with asynchronous busy/ready pins.
- Undefined: rdy = dev_ready_i, sampled directly. Use this when ready is already in the clk_i domain.

Test Plan:
All scenarios use NDEV=2, RESETLEN=8, HOLDOFF=4, TIMEOUT=16, macro undefined, unless stated.
- Reset: resetn_i=0 for 3 cycles with en_i=1 -> dev_reset_o=2'b11, acq_en_o=0, busy_o=0, done_o=0, fault_mask_o=0.
- Nominal: en_i=1, dev_ready_i=2'b11 held.
  - dev_reset_o=2'b11 for exactly 8 cycles after ASSERT entry;
  - bit0 drops, then bit1 drops 6 cycles later;
  - acq_en_o=1 and done_o=1 exactly 20 cycles after ASSERT entry; fault_o=0.
- Timeout: dev_ready_i[1] stuck 0 -> after 16 WAIT_RDY cycles, fault_mask_o=2'b10, dev_reset_o=2'b10, state FAULT, fault_o=1, acq_en_o=0.
- Restart: pulse restart_i in RUN -> next edge dev_reset_o=2'b11, acq_en_o=0, busy_o=1. Pulse again mid-HOLDOFF -> ASSERT re-entered with the 8-cycle count restarted.
- Enable drop and priority: en_i=0 mid-WAIT_RDY -> IDLE next edge with fault_mask_o=0. en_i=0 and restart_i=1 on the same edge -> IDLE. Ready rising on the exact timeout cycle -> no fault bit set.
- Sync build: with DAS_READY_SYNC_EN defined and ready arriving 1 cycle after HOLDOFF ends -> advance to the next device occurs 2 cycles later than in the unsynced build.
